// File: rtl/uart_rx_8n1_if.sv
// Serial-receive bundle: rx line into the receiver, received byte and status strobes out.
interface uart_rx_8n1_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data_out, data_valid, frame_err, busy);
  modport slave  (output rx, input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversample tick, 2-flop synchroniser, mid-bit sampling,
// one-cycle data_valid / frame_err strobes.
module uart_rx_8n1 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_8n1_if.master  bus
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s, rx_prev;
  logic [1:0]      settle;
  logic            armed;
  logic            fall, start_det, tick;
  logic [TW-1:0]   tcnt;
  logic [SW-1:0]   scnt, scnt_n;
  logic [2:0]      bcnt, bcnt_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      dout_q, dout_n;
  logic            dv_q, dv_n, fe_q, fe_n;

  // The synchroniser resets to idle-high, so a line already low at reset release
  // would look like an edge; only arm once a real high has propagated through.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_m    <= bus.rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  assign fall      = armed & rx_prev & ~rx_s;
  assign start_det = (state == IDLE) & fall;
  assign tick      = (tcnt == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)                    tcnt <= '0;
    else if (start_det || tick) tcnt <= '0;
    else                        tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      state  <= state_n;
      scnt   <= scnt_n;
      bcnt   <= bcnt_n;
      shreg  <= shreg_n;
      dout_q <= dout_n;
      dv_q   <= dv_n;
      fe_q   <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    dout_n  = dout_q;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_n = START;
          scnt_n  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
            scnt_n = '0;
            bcnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            shreg_n = {rx_s, shreg[7:1]};
            scnt_n  = '0;
            if (bcnt == 3'd7) state_n = STOP;
            else              bcnt_n  = bcnt + 3'd1;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets an immediately following start edge be caught.
        if (tick) begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            if (rx_s) begin
              dout_n = shreg;
              dv_n   = 1'b1;
            end else begin
              fe_n   = 1'b1;
            end
            state_n = IDLE;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at DIV=10 (160 clk per bit).
module tb_uart_rx_8n1;
  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   fails = 0;

  uart_rx_8n1_if bus();

  uart_rx_8n1 #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: everything seen on the outputs, sampled on the falling edge.
  logic [7:0] dv_data[$];
  int         dv_cyc[$];
  int         fe_cnt = 0;
  int         busy_hi = 0;
  int         both_cnt = 0;
  int         consec_cnt = 0;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_data.push_back(bus.data_out);
      dv_cyc.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.busy === 1'b1) busy_hi++;
    if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    if ((bus.data_valid | bus.frame_err) === 1'b1 && prev_strobe) consec_cnt++;
    prev_strobe = (bus.data_valid | bus.frame_err) === 1'b1;
  end

  logic [7:0] last_good = 8'h00;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int start_cyc);
    @(negedge clk);
    bus.rx = 1'b0;
    start_cyc = cyc;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_clk(BIT);
    end
    bus.rx = stop_ok;
    wait_clk(BIT);
  endtask

  task automatic test_reset;
    bus.rx = 1'b1;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    tests_run++;
    if (bus.data_out !== 8'h00) begin fails++; $display("FAIL reset data_out got %h want 00", bus.data_out); end
    tests_run++;
    if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset data_valid got %b want 0", bus.data_valid); end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset frame_err got %b want 0", bus.frame_err); end
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", bus.busy); end
    wait_clk(5000);
    tests_run++;
    if (dv_data.size() != 0 || fe_cnt != 0 || busy_hi != 0) begin
      fails++;
      $display("FAIL idle_quiet dv=%0d fe=%0d busy_cycles=%0d want all 0", dv_data.size(), fe_cnt, busy_hi);
    end
  endtask

  task automatic test_single;
    int base, st, lat;
    base = dv_data.size();
    send_frame(8'h55, 1'b1, st);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    tests_run++;
    if (dv_data.size() - base != 1) begin
      fails++; $display("FAIL single_count got %0d want 1", dv_data.size() - base);
    end else begin
      tests_run++;
      if (dv_data[base] !== 8'h55) begin fails++; $display("FAIL single_data got %h want 55", dv_data[base]); end
      lat = dv_cyc[base] - st;
      tests_run++;
      if (lat < 1515 || lat > 1535) begin fails++; $display("FAIL single_latency got %0d want 1515..1535", lat); end
      last_good = 8'h55;
    end
  endtask

  task automatic test_back_to_back;
    int base, fe0, st, d;
    base = dv_data.size();
    fe0  = fe_cnt;
    send_frame(8'hA3, 1'b1, st);
    send_frame(8'h0F, 1'b1, st);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    tests_run++;
    if (dv_data.size() - base != 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", dv_data.size() - base);
    end else begin
      tests_run++;
      if (dv_data[base] !== 8'hA3 || dv_data[base+1] !== 8'h0F) begin
        fails++; $display("FAIL b2b_data got %h %h want a3 0f", dv_data[base], dv_data[base+1]);
      end
      d = dv_cyc[base+1] - dv_cyc[base];
      tests_run++;
      if (d < 1584 || d > 1616) begin fails++; $display("FAIL b2b_spacing got %0d want 1584..1616", d); end
      last_good = 8'h0F;
    end
    tests_run++;
    if (fe_cnt != fe0) begin fails++; $display("FAIL b2b_frame_err got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_glitch;
    int base, fe0, b0;
    base = dv_data.size();
    fe0  = fe_cnt;
    b0   = busy_hi;
    @(negedge clk);
    bus.rx = 1'b0;
    wait_clk(40);
    bus.rx = 1'b1;
    wait_clk(3 * BIT);
    tests_run++;
    if (busy_hi == b0) begin fails++; $display("FAIL glitch_busy_pulse got 0 busy cycles want >0"); end
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_idle busy got %b want 0", bus.busy); end
    tests_run++;
    if (dv_data.size() != base || fe_cnt != fe0) begin
      fails++; $display("FAIL glitch_strobes dv=%0d fe=%0d want 0 0", dv_data.size() - base, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    int base, fe0, st;
    base = dv_data.size();
    fe0  = fe_cnt;
    send_frame(8'hC3, 1'b0, st);
    wait_clk(3 * BIT);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    tests_run++;
    if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fe0); end
    tests_run++;
    if (dv_data.size() != base) begin fails++; $display("FAIL ferr_dv got %0d want 0", dv_data.size() - base); end
    tests_run++;
    if (bus.data_out !== last_good) begin fails++; $display("FAIL ferr_hold got %h want %h", bus.data_out, last_good); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int base, st;
    b    = 8'h7E;
    base = dv_data.size();
    @(negedge clk);
    bus.rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      wait_clk(BIT);
    end
    bus.rx = b[4];
    wait_clk(BIT / 2);
    rst = 1'b1;
    wait_clk(1);
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle busy got %b want 0", bus.busy); end
    wait_clk(2);
    rst = 1'b0;
    bus.rx = 1'b1;
    last_good = 8'h00;
    wait_clk(3 * BIT);
    tests_run++;
    if (dv_data.size() != base) begin fails++; $display("FAIL rstmid_abort got %0d strobes want 0", dv_data.size() - base); end
    send_frame(8'h81, 1'b1, st);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    tests_run++;
    if (dv_data.size() - base != 1 || dv_data[dv_data.size()-1] !== 8'h81) begin
      fails++; $display("FAIL rstmid_next count=%0d want 1 with 81", dv_data.size() - base);
    end else last_good = 8'h81;
  endtask

  task automatic test_reset_rx_low;
    int base, b0, st;
    bus.rx = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    last_good = 8'h00;
    base = dv_data.size();
    b0 = busy_hi;
    wait_clk(3 * BIT);
    tests_run++;
    if (busy_hi != b0 || dv_data.size() != base) begin
      fails++; $display("FAIL rxlow_no_start busy_cycles=%0d dv=%0d want 0 0", busy_hi - b0, dv_data.size() - base);
    end
    bus.rx = 1'b1;
    wait_clk(BIT);
    send_frame(8'h3C, 1'b1, st);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    tests_run++;
    if (dv_data.size() - base != 1 || dv_data[dv_data.size()-1] !== 8'h3C) begin
      fails++; $display("FAIL rxlow_rearm count=%0d want 1 with 3c", dv_data.size() - base);
    end else last_good = 8'h3C;
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       ok;
    int base, fe0, exp_fe, st, gap, errs;
    base = dv_data.size();
    fe0 = fe_cnt;
    exp_fe = 0;
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin exp_q.push_back(b); last_good = b; end
      else exp_fe++;
      send_frame(b, ok, st);
      bus.rx = 1'b1;
      gap = ok ? $urandom_range(0, 200) : $urandom_range(20, 200);
      if (gap > 0) wait_clk(gap);
    end
    wait_clk(2 * BIT);
    tests_run++;
    if (dv_data.size() - base != exp_q.size()) begin
      fails++; $display("FAIL rand_count got %0d want %0d", dv_data.size() - base, exp_q.size());
    end else begin
      errs = 0;
      foreach (exp_q[i]) if (dv_data[base+i] !== exp_q[i]) errs++;
      tests_run++;
      if (errs != 0) begin fails++; $display("FAIL rand_data %0d bytes differ from sent bytes", errs); end
    end
    tests_run++;
    if (fe_cnt - fe0 != exp_fe) begin fails++; $display("FAIL rand_frame_err got %0d want %0d", fe_cnt - fe0, exp_fe); end
    tests_run++;
    if (bus.data_out !== last_good) begin fails++; $display("FAIL rand_last got %h want %h", bus.data_out, last_good); end
  endtask

  task automatic test_strobe_rules;
    tests_run++;
    if (both_cnt != 0) begin fails++; $display("FAIL strobe_overlap got %0d cycles want 0", both_cnt); end
    tests_run++;
    if (consec_cnt != 0) begin fails++; $display("FAIL strobe_consecutive got %0d want 0", consec_cnt); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_reset_rx_low;
    test_random;
    test_strobe_rules;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
